// File: rtl/instr_control_pkg.sv
// Shared MIPS decode constants: opcode/funct/REGIMM/COP0 codes, field ranges,
// and the one-hot flag bundle produced by the instruction decoder.
package instr_control_pkg;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_SLTIU   = 6'b001011;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_COP0    = 6'b010000;
   localparam logic [5:0] OP_LB      = 6'b100000;
   localparam logic [5:0] OP_LH      = 6'b100001;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_LBU     = 6'b100100;
   localparam logic [5:0] OP_LHU     = 6'b100101;
   localparam logic [5:0] OP_SB      = 6'b101000;
   localparam logic [5:0] OP_SH      = 6'b101001;
   localparam logic [5:0] OP_SW      = 6'b101011;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_SLLV  = 6'b000100;
   localparam logic [5:0] F_SRLV  = 6'b000110;
   localparam logic [5:0] F_SRAV  = 6'b000111;
   localparam logic [5:0] F_JR    = 6'b001000;
   localparam logic [5:0] F_JALR  = 6'b001001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   localparam logic [4:0] RT_BLTZ = 5'b00000;
   localparam logic [4:0] RT_BGEZ = 5'b00001;

   localparam logic [4:0] RS_MFC0 = 5'b00000;
   localparam logic [4:0] RS_MTC0 = 5'b00100;

   localparam logic [31:0] ERET_WORD = 32'h4200_0018;

   typedef struct packed {
      logic add, addu, sub, subu, And, Or, Xor, Nor, slt, sltu;
      logic sll, srl, sra, sllv, srlv, srav;
      logic jr, jalr;
      logic mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
      logic addi, addiu, andi, ori, xori, lui, slti, sltiu;
      logic lb, lbu, lh, lhu, lw, sb, sh, sw;
      logic beq, bne, blez, bgtz, bltz, bgez, j, jal;
      logic mfc0, mtc0, eret;
      logic ri;
   } flags_t;

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational instruction word to one-hot flag decode.
module instr_decode_comb
   import instr_control_pkg::*;
(
   input  logic [31:0] IR_i,
   output flags_t      flags_o
);

   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [5:0] funct;

   assign op    = IR_i[OP_HI:OP_LO];
   assign rs    = IR_i[RS_HI:RS_LO];
   assign rt    = IR_i[RT_HI:RT_LO];
   assign funct = IR_i[FUNCT_HI:FUNCT_LO];

   always_comb begin
      flags_o = '0;
      case (op)
         OP_SPECIAL: begin
            case (funct)
               F_ADD:   flags_o.add   = 1'b1;
               F_ADDU:  flags_o.addu  = 1'b1;
               F_SUB:   flags_o.sub   = 1'b1;
               F_SUBU:  flags_o.subu  = 1'b1;
               F_AND:   flags_o.And   = 1'b1;
               F_OR:    flags_o.Or    = 1'b1;
               F_XOR:   flags_o.Xor   = 1'b1;
               F_NOR:   flags_o.Nor   = 1'b1;
               F_SLT:   flags_o.slt   = 1'b1;
               F_SLTU:  flags_o.sltu  = 1'b1;
               F_SLL:   flags_o.sll   = 1'b1;
               F_SRL:   flags_o.srl   = 1'b1;
               F_SRA:   flags_o.sra   = 1'b1;
               F_SLLV:  flags_o.sllv  = 1'b1;
               F_SRLV:  flags_o.srlv  = 1'b1;
               F_SRAV:  flags_o.srav  = 1'b1;
               F_JR:    flags_o.jr    = 1'b1;
               F_JALR:  flags_o.jalr  = 1'b1;
               F_MFHI:  flags_o.mfhi  = 1'b1;
               F_MTHI:  flags_o.mthi  = 1'b1;
               F_MFLO:  flags_o.mflo  = 1'b1;
               F_MTLO:  flags_o.mtlo  = 1'b1;
               F_MULT:  flags_o.mult  = 1'b1;
               F_MULTU: flags_o.multu = 1'b1;
               F_DIV:   flags_o.div   = 1'b1;
               F_DIVU:  flags_o.divu  = 1'b1;
               default: ;
            endcase
         end
         OP_REGIMM: begin
            case (rt)
               RT_BLTZ: flags_o.bltz = 1'b1;
               RT_BGEZ: flags_o.bgez = 1'b1;
               default: ;
            endcase
         end
         OP_COP0: begin
            // eret is a full-word match; its rs field (10000) cannot alias mfc0/mtc0
            if (IR_i == ERET_WORD) begin
               flags_o.eret = 1'b1;
            end else begin
               case (rs)
                  RS_MFC0: flags_o.mfc0 = 1'b1;
                  RS_MTC0: flags_o.mtc0 = 1'b1;
                  default: ;
               endcase
            end
         end
         OP_J:     flags_o.j     = 1'b1;
         OP_JAL:   flags_o.jal   = 1'b1;
         OP_BEQ:   flags_o.beq   = 1'b1;
         OP_BNE:   flags_o.bne   = 1'b1;
         OP_BLEZ:  flags_o.blez  = 1'b1;
         OP_BGTZ:  flags_o.bgtz  = 1'b1;
         OP_ADDI:  flags_o.addi  = 1'b1;
         OP_ADDIU: flags_o.addiu = 1'b1;
         OP_SLTI:  flags_o.slti  = 1'b1;
         OP_SLTIU: flags_o.sltiu = 1'b1;
         OP_ANDI:  flags_o.andi  = 1'b1;
         OP_ORI:   flags_o.ori   = 1'b1;
         OP_XORI:  flags_o.xori  = 1'b1;
         OP_LUI:   flags_o.lui   = 1'b1;
         OP_LB:    flags_o.lb    = 1'b1;
         OP_LH:    flags_o.lh    = 1'b1;
         OP_LW:    flags_o.lw    = 1'b1;
         OP_LBU:   flags_o.lbu   = 1'b1;
         OP_LHU:   flags_o.lhu   = 1'b1;
         OP_SB:    flags_o.sb    = 1'b1;
         OP_SH:    flags_o.sh    = 1'b1;
         OP_SW:    flags_o.sw    = 1'b1;
         default: ;
      endcase
      // ri is still 0 here, so this reduces over the instruction flags only
      flags_o.ri = ~(|flags_o);
   end

endmodule

// File: rtl/instr_control.sv
// Instruction decoder top: combinational decode followed by a single
// reset-qualified register bank, giving a one-cycle-latency flag interface.
module instr_control
   import instr_control_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR,
   output logic add, addu, sub, subu, And, Or, Xor, Nor, slt, sltu,
   output logic sll, srl, sra, sllv, srlv, srav,
   output logic jr, jalr,
   output logic mult, multu, div, divu, mfhi, mflo, mthi, mtlo,
   output logic addi, addiu, andi, ori, xori, lui, slti, sltiu,
   output logic lb, lbu, lh, lhu, lw, sb, sh, sw,
   output logic beq, bne, blez, bgtz, bltz, bgez, j, jal,
   output logic mfc0, mtc0, eret,
   output logic ri
);

   flags_t flags_d;
   flags_t flags_q;

   instr_decode_comb u_decode (
      .IR_i    (IR),
      .flags_o (flags_d)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign add   = flags_q.add;
   assign addu  = flags_q.addu;
   assign sub   = flags_q.sub;
   assign subu  = flags_q.subu;
   assign And   = flags_q.And;
   assign Or    = flags_q.Or;
   assign Xor   = flags_q.Xor;
   assign Nor   = flags_q.Nor;
   assign slt   = flags_q.slt;
   assign sltu  = flags_q.sltu;
   assign sll   = flags_q.sll;
   assign srl   = flags_q.srl;
   assign sra   = flags_q.sra;
   assign sllv  = flags_q.sllv;
   assign srlv  = flags_q.srlv;
   assign srav  = flags_q.srav;
   assign jr    = flags_q.jr;
   assign jalr  = flags_q.jalr;
   assign mult  = flags_q.mult;
   assign multu = flags_q.multu;
   assign div   = flags_q.div;
   assign divu  = flags_q.divu;
   assign mfhi  = flags_q.mfhi;
   assign mflo  = flags_q.mflo;
   assign mthi  = flags_q.mthi;
   assign mtlo  = flags_q.mtlo;
   assign addi  = flags_q.addi;
   assign addiu = flags_q.addiu;
   assign andi  = flags_q.andi;
   assign ori   = flags_q.ori;
   assign xori  = flags_q.xori;
   assign lui   = flags_q.lui;
   assign slti  = flags_q.slti;
   assign sltiu = flags_q.sltiu;
   assign lb    = flags_q.lb;
   assign lbu   = flags_q.lbu;
   assign lh    = flags_q.lh;
   assign lhu   = flags_q.lhu;
   assign lw    = flags_q.lw;
   assign sb    = flags_q.sb;
   assign sh    = flags_q.sh;
   assign sw    = flags_q.sw;
   assign beq   = flags_q.beq;
   assign bne   = flags_q.bne;
   assign blez  = flags_q.blez;
   assign bgtz  = flags_q.bgtz;
   assign bltz  = flags_q.bltz;
   assign bgez  = flags_q.bgez;
   assign j     = flags_q.j;
   assign jal   = flags_q.jal;
   assign mfc0  = flags_q.mfc0;
   assign mtc0  = flags_q.mtc0;
   assign eret  = flags_q.eret;
   assign ri    = flags_q.ri;

endmodule

// File: tb/tb_instr_control.sv
// Directed bench for instr_control: reset, R/I/J/REGIMM/COP0 sweeps,
// reserved encodings and back-to-back decode.
module tb_instr_control;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] IR = 32'h0;

   logic add, addu, sub, subu, And, Or, Xor, Nor, slt, sltu;
   logic sll, srl, sra, sllv, srlv, srav, jr, jalr;
   logic mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
   logic addi, addiu, andi, ori, xori, lui, slti, sltiu;
   logic lb, lbu, lh, lhu, lw, sb, sh, sw;
   logic beq, bne, blez, bgtz, bltz, bgez, j, jal;
   logic mfc0, mtc0, eret, ri;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_control dut (
      .clk(clk), .reset(reset), .IR(IR),
      .add(add), .addu(addu), .sub(sub), .subu(subu), .And(And), .Or(Or),
      .Xor(Xor), .Nor(Nor), .slt(slt), .sltu(sltu),
      .sll(sll), .srl(srl), .sra(sra), .sllv(sllv), .srlv(srlv), .srav(srav),
      .jr(jr), .jalr(jalr),
      .mult(mult), .multu(multu), .div(div), .divu(divu),
      .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
      .addi(addi), .addiu(addiu), .andi(andi), .ori(ori), .xori(xori),
      .lui(lui), .slti(slti), .sltiu(sltiu),
      .lb(lb), .lbu(lbu), .lh(lh), .lhu(lhu), .lw(lw), .sb(sb), .sh(sh), .sw(sw),
      .beq(beq), .bne(bne), .blez(blez), .bgtz(bgtz), .bltz(bltz), .bgez(bgez),
      .j(j), .jal(jal),
      .mfc0(mfc0), .mtc0(mtc0), .eret(eret), .ri(ri)
   );

   // Bit positions of each flag inside obs (add at bit 0, ri at bit 53)
   localparam int I_ADD = 0,  I_SUB = 2,  I_SLL = 10;
   localparam int I_LW = 38,  I_SW = 41,  I_BEQ = 42, I_BLTZ = 46, I_BGEZ = 47;
   localparam int I_JAL = 49, I_MFC0 = 50, I_MTC0 = 51, I_ERET = 52, I_RI = 53;

   logic [53:0] obs;
   assign obs = {ri, eret, mtc0, mfc0, jal, j, bgez, bltz, bgtz, blez, bne, beq,
                 sw, sh, sb, lw, lhu, lh, lbu, lb,
                 sltiu, slti, lui, xori, ori, andi, addiu, addi,
                 mtlo, mthi, mflo, mfhi, divu, div, multu, mult,
                 jalr, jr, srav, srlv, sllv, sra, srl, sll,
                 sltu, slt, Nor, Xor, Or, And, subu, sub, addu, add};

   function automatic logic [53:0] onehot(input int idx);
      logic [53:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Present IR before the next rising edge, then sample just after it
   task automatic step(input logic [31:0] ir);
      @(negedge clk);
      IR = ir;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         step(32'h0000_0020);
         total++;
         if (obs !== 54'd0) begin
            bad++;
            $display("FAIL reset_hold[%0d]: got %h want %h", c, obs, 54'd0);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (obs !== onehot(I_ADD)) begin
         bad++;
         $display("FAIL reset_release_add: got %h want %h", obs, onehot(I_ADD));
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fn [0:25];
      fn = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
             6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
             6'b000011, 6'b000100, 6'b000110, 6'b000111, 6'b001000, 6'b001001,
             6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010,
             6'b010001, 6'b010011};
      for (int k = 0; k < 26; k++) begin
         step({6'b000000, 20'h12345, fn[k]});
         total++;
         if (obs !== onehot(k)) begin
            bad++;
            $display("FAIL rtype_funct_%b: got %h want %h", fn[k], obs, onehot(k));
         end
      end
      step(32'h0110_4822);
      total++;
      if (obs !== onehot(I_SUB)) begin
         bad++;
         $display("FAIL rtype_sub_word: got %h want %h", obs, onehot(I_SUB));
      end
   endtask

   task automatic test_itype();
      logic [5:0] opc [0:21];
      int         idx [0:21];
      opc = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
              6'b001010, 6'b001011, 6'b100000, 6'b100100, 6'b100001, 6'b100101,
              6'b100011, 6'b101000, 6'b101001, 6'b101011, 6'b000100, 6'b000101,
              6'b000110, 6'b000111, 6'b000010, 6'b000011};
      idx = '{26, 27, 28, 29, 30, 31, 32, 33, 34, 35, 36, 37,
              38, 39, 40, 41, 42, 43, 44, 45, 48, 49};
      for (int k = 0; k < 22; k++) begin
         step({opc[k], 26'h2A5_5A5A});
         total++;
         if (obs !== onehot(idx[k])) begin
            bad++;
            $display("FAIL itype_op_%b: got %h want %h", opc[k], obs, onehot(idx[k]));
         end
      end
      step(32'h8C08_0004);
      total++;
      if (obs !== onehot(I_LW)) begin
         bad++;
         $display("FAIL lw_word: got %h want %h", obs, onehot(I_LW));
      end
      step(32'h0501_FFFF);
      total++;
      if (obs !== onehot(I_BGEZ)) begin
         bad++;
         $display("FAIL bgez_word: got %h want %h", obs, onehot(I_BGEZ));
      end
      step(32'h0500_FFFF);
      total++;
      if (obs !== onehot(I_BLTZ)) begin
         bad++;
         $display("FAIL bltz_word: got %h want %h", obs, onehot(I_BLTZ));
      end
      step(32'h0C00_0010);
      total++;
      if (obs !== onehot(I_JAL)) begin
         bad++;
         $display("FAIL jal_word: got %h want %h", obs, onehot(I_JAL));
      end
   endtask

   task automatic test_cp0();
      logic [31:0] w   [0:4];
      int          idx [0:4];
      w   = '{32'h4008_6000, 32'h4088_6000, 32'h4200_0018, 32'h4200_0019, 32'h4040_0000};
      idx = '{I_MFC0, I_MTC0, I_ERET, I_RI, I_RI};
      for (int k = 0; k < 5; k++) begin
         step(w[k]);
         total++;
         if (obs !== onehot(idx[k])) begin
            bad++;
            $display("FAIL cp0_%h: got %h want %h", w[k], obs, onehot(idx[k]));
         end
      end
   endtask

   task automatic test_reserved();
      logic [31:0] w   [0:4];
      int          idx [0:4];
      w   = '{32'hFC00_0000, 32'h0000_0001, 32'h0502_0000, 32'h0000_0000, 32'h0000_003F};
      idx = '{I_RI, I_RI, I_RI, I_SLL, I_RI};
      for (int k = 0; k < 5; k++) begin
         step(w[k]);
         total++;
         if (obs !== onehot(idx[k])) begin
            bad++;
            $display("FAIL reserved_%h: got %h want %h", w[k], obs, onehot(idx[k]));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w   [0:2];
      int          idx [0:2];
      w   = '{32'h8C08_0004, 32'hAC09_0008, 32'h1109_FFFC};
      idx = '{I_LW, I_SW, I_BEQ};
      @(negedge clk);
      IR = w[0];
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         total++;
         if (obs !== onehot(idx[(c - 1) % 3]) || $countones(obs) > 1) begin
            bad++;
            $display("FAIL b2b_cycle%0d: got %h want %h", c, obs, onehot(idx[(c - 1) % 3]));
         end
         IR = w[c % 3];
      end
   endtask

   task automatic test_reset_priority();
      step(32'h8C08_0004);
      @(negedge clk);
      reset = 1'b0;
      IR = 32'hAC09_0008;
      @(posedge clk);
      #1;
      total++;
      if (obs !== 54'd0) begin
         bad++;
         $display("FAIL reset_priority: got %h want %h", obs, 54'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (obs !== onehot(I_SW)) begin
         bad++;
         $display("FAIL reset_priority_release: got %h want %h", obs, onehot(I_SW));
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_itype();
      test_cp0();
      test_reserved();
      test_back_to_back();
      test_reset_priority();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_control.md
# instr_control

Instruction decoder for the five-stage MIPS pipeline with CP0 support. Takes a 32-bit instruction word and produces one-hot instruction flags consumed by the ID/EX register and the hazard, forwarding and exception logic. The flags drive destination-register selection, immediate extension and CP0 write-enable. Decode is combinational, and the flags are registered once so the block presents a clean one-cycle-latency interface.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-low; when low at a rising edge, all outputs clear.
- IR  in  32  instruction word. Fields: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
- Flag outputs, all `out 1`, one per instruction:
  - R-type ALU: add, addu, sub, subu, And, Or, Xor, Nor, slt, sltu.
  - Shifts: sll, srl, sra, sllv, srlv, srav.
  - Register jumps: jr, jalr.
  - HI/LO: mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
  - Immediate ALU: addi, addiu, andi, ori, xori, lui, slti, sltiu.
  - Loads and stores: lb, lbu, lh, lhu, lw, sb, sh, sw.
  - Branches and jumps: beq, bne, blez, bgtz, bltz, bgez, j, jal.
  - CP0: mfc0, mtc0, eret.
- ri  out  1  reserved instruction: IR matches none of the encodings listed under Operation.

## Operation
Exact-match encodings (binary):
- op=000000, selected by funct:
  - 100000 add, 100001 addu, 100010 sub, 100011 subu
  - 100100 And, 100101 Or, 100110 Xor, 100111 Nor
  - 101010 slt, 101011 sltu
  - 000000 sll, 000010 srl, 000011 sra, 000100 sllv, 000110 srlv, 000111 srav
  - 001000 jr, 001001 jalr
  - 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo
  - 011000 mult, 011001 multu, 011010 div, 011011 divu
- op=000001 (REGIMM): rt=00000 bltz, rt=00001 bgez.
- Other opcodes:
  - 000010 j, 000011 jal
  - 000100 beq, 000101 bne, 000110 blez, 000111 bgtz
  - 001000 addi, 001001 addiu, 001010 slti, 001011 sltiu
  - 001100 andi, 001101 ori, 001110 xori, 001111 lui
  - 100000 lb, 100001 lh, 100011 lw, 100100 lbu, 100101 lhu
  - 101000 sb, 101001 sh, 101011 sw
- op=010000 (COP0):
  - rs=00000 is mfc0; rs=00100 is mtc0.
  - eret only when IR == 32'h4200_0018 exactly.
- Only op, funct, rt (for REGIMM) and rs (for COP0) participate in the match. Other fields are don't-care, except for eret.
- At most one output is high per cycle. When no flag matches, ri=1.
- IR=32'h0 (nop) decodes as sll=1, ri=0.
- Unlisted funct under op=0, unlisted rt under REGIMM, and unlisted COP0 words (other than exact eret) all give ri=1.

## Timing
- Outputs are registered. IR sampled at edge N appears on the flags after edge N; latency is 1 cycle.
- No combinational path from IR to any output.
- Reset value: every flag 0, including ri.
- Reset has priority over a simultaneous IR change.
- In the first edge after reset releases, the flags reflect IR sampled at that edge.
- There is no enable; a new decode happens every cycle.
- X on IR is not required to produce a defined decode.

## Structure
- Shared package (also used by the ID/EX register and ALU control):
  - opcode constants, funct constants, REGIMM rt codes, COP0 rs codes;
  - the ERET word constant;
  - field-range constants rs/rt/rd/funct.
- One natural sub-module, `instr_decode_comb`: purely combinational IR-to-flags decode.
- The top level holds only the reset-qualified output register bank.

## Test plan
- Reset: reset=0 for 2 cycles with IR=32'h0000_0020 (add). All outputs stay 0. After release, add=1 one cycle later.
- R-type sweep: every listed funct with op=0, e.g. 32'h0110_4822 (sub). Exactly the matching flag is 1, ri=0, with 1-cycle latency.
- I/J/REGIMM sweep:
  - 32'h8C08_0004 (lw) gives lw=1.
  - 32'h0501_FFFF gives bgez=1.
  - 32'h0500_FFFF gives bltz=1.
  - 32'h0C00_0010 gives jal=1.
- CP0 decode:
  - 32'h4008_6000 gives mfc0=1.
  - 32'h4088_6000 gives mtc0=1.
  - 32'h4200_0018 gives eret=1.
  - 32'h4200_0019 gives ri=1.
- Reserved: 32'hFC00_0000, 32'h0000_0001 (funct 000001) and 32'h0502_0000 each give ri=1 with all other flags 0. 32'h0000_0000 gives sll=1.
- Back-to-back: alternate lw/sw/beq every cycle. The outputs follow with exactly 1-cycle delay and never show two flags high at once.
